// File: rtl/load_buffer_pkg.sv
// load_buffer_pkg: shared sizes, slot/entry types and issue-FSM encoding for the load buffer
package load_buffer_pkg;
    localparam int LDB_NUM   = 16;
    localparam int LDB_WIDTH = 4;
    localparam int XLEN      = 32;
    localparam int PRF_WIDTH = 6;
    localparam int ROB_WIDTH = 5;
    typedef enum logic [1:0] {FREE, WAIT, ISSUED} ldb_state_t;
    typedef struct packed {
        logic [XLEN-1:0]      addr;
        logic [1:0]           size;
        logic                 is_unsigned;
        logic [PRF_WIDTH-1:0] prd;
        logic [ROB_WIDTH-1:0] rob;
        ldb_state_t           state;
    } ldb_entry_t;
    typedef logic [1:0] ldb_fsm_t;
    localparam ldb_fsm_t IDLE  = 2'd0;
    localparam ldb_fsm_t RESP  = 2'd1;
    localparam ldb_fsm_t DRAIN = 2'd2;
endpackage

// File: rtl/load_buffer_if.sv
// load_buffer_if: dispatch allocation, D-cache read port and writeback bundles
interface load_buffer_if;
    import load_buffer_pkg::*;
    logic                 alloc_valid;
    logic                 alloc_ready;
    logic [XLEN-1:0]      alloc_addr;
    logic [1:0]           alloc_size;
    logic                 alloc_unsigned;
    logic [PRF_WIDTH-1:0] alloc_prd;
    logic [ROB_WIDTH-1:0] alloc_rob;
    logic                 mem_req_valid;
    logic [XLEN-1:0]      mem_req_addr;
    logic                 mem_req_ready;
    logic                 mem_resp_valid;
    logic [XLEN-1:0]      mem_resp_data;
    logic                 wb_valid;
    logic [PRF_WIDTH-1:0] wb_prd;
    logic [ROB_WIDTH-1:0] wb_rob;
    logic [XLEN-1:0]      wb_data;
    modport slave (
        input  alloc_valid, alloc_addr, alloc_size, alloc_unsigned, alloc_prd, alloc_rob,
        output alloc_ready,
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output wb_valid, wb_prd, wb_rob, wb_data
    );
    modport master (
        output alloc_valid, alloc_addr, alloc_size, alloc_unsigned, alloc_prd, alloc_rob,
        input  alloc_ready,
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  wb_valid, wb_prd, wb_rob, wb_data
    );
endinterface

// File: rtl/load_buffer_select.sv
// load_buffer_select: priority picker returning the lowest-index slot that is not valid
module load_buffer_select
    import load_buffer_pkg::*;
(
    input  logic [LDB_NUM-1:0]   valid_i,
    output logic [LDB_WIDTH-1:0] select_index_o,
    output logic                 select_index_valid_o
);
    always_comb begin
        select_index_o       = '0;
        select_index_valid_o = 1'b0;
        for (int i = LDB_NUM - 1; i >= 0; i--) begin
            if (!valid_i[i]) begin
                select_index_o       = LDB_WIDTH'(i);
                select_index_valid_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/load_buffer.sv
// load_buffer: 16-entry load buffer; issues one D-cache read at a time in slot order
// and writes the size/sign-formatted result back to the PRF and ROB.
module load_buffer
    import load_buffer_pkg::*;
(
    input logic          clk,
    input logic          rst,
    input logic          flush_i,
    load_buffer_if.slave bus
);
    ldb_entry_t           ent_q [LDB_NUM];
    ldb_entry_t           ent_d [LDB_NUM];
    ldb_fsm_t             fsm_q, fsm_d;
    logic [LDB_WIDTH-1:0] cur_q, cur_d;
    logic                 wb_valid_q, wb_valid_d;
    logic [PRF_WIDTH-1:0] wb_prd_q, wb_prd_d;
    logic [ROB_WIDTH-1:0] wb_rob_q, wb_rob_d;
    logic [XLEN-1:0]      wb_data_q, wb_data_d;
    logic [LDB_NUM-1:0]   busy;
    logic [LDB_WIDTH-1:0] sel_idx, iss_idx;
    logic                 sel_vld, iss_vld, alloc_ready, alloc_fire, req_fire;

    function automatic logic [XLEN-1:0] ld_extend(input logic [XLEN-1:0] w, input logic [1:0] off,
                                                  input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = w[{off[1], 4'b0000} +: 16];
        return size == 2'd0 ? {{24{~uns & b[7]}}, b} :
               size == 2'd1 ? {{16{~uns & h[15]}}, h} : w;
    endfunction

    always_comb begin
        for (int i = 0; i < LDB_NUM; i++) busy[i] = ent_q[i].state != FREE;
    end

    load_buffer_select u_select (
        .valid_i              (busy),
        .select_index_o       (sel_idx),
        .select_index_valid_o (sel_vld)
    );

    always_comb begin
        iss_idx = '0;
        iss_vld = 1'b0;
        for (int i = LDB_NUM - 1; i >= 0; i--) begin
            if (ent_q[i].state == WAIT) begin
                iss_idx = LDB_WIDTH'(i);
                iss_vld = 1'b1;
            end
        end
    end

    assign alloc_ready       = sel_vld && !flush_i;
    assign alloc_fire        = bus.alloc_valid && alloc_ready;
    assign bus.alloc_ready   = alloc_ready;
    assign bus.mem_req_valid = fsm_q == IDLE && iss_vld;
    assign bus.mem_req_addr  = {ent_q[iss_idx].addr[XLEN-1:2], 2'b00};
    assign req_fire          = bus.mem_req_valid && bus.mem_req_ready;
    assign bus.wb_valid      = wb_valid_q;
    assign bus.wb_prd        = wb_prd_q;
    assign bus.wb_rob        = wb_rob_q;
    assign bus.wb_data       = wb_data_q;

    always_comb begin
        ent_d      = ent_q;
        fsm_d      = fsm_q;
        cur_d      = cur_q;
        wb_valid_d = 1'b0;
        wb_prd_d   = wb_prd_q;
        wb_rob_d   = wb_rob_q;
        wb_data_d  = wb_data_q;
        if (alloc_fire) begin
            ent_d[sel_idx].addr        = bus.alloc_addr;
            ent_d[sel_idx].size        = bus.alloc_size;
            ent_d[sel_idx].is_unsigned = bus.alloc_unsigned;
            ent_d[sel_idx].prd         = bus.alloc_prd;
            ent_d[sel_idx].rob         = bus.alloc_rob;
            ent_d[sel_idx].state       = WAIT;
        end
        // A request accepted during a flush still gets a response, so it must be drained.
        if (req_fire) begin
            ent_d[iss_idx].state = ISSUED;
            cur_d                = iss_idx;
            fsm_d                = flush_i ? DRAIN : RESP;
        end
        if (fsm_q == RESP && bus.mem_resp_valid) begin
            ent_d[cur_q].state = FREE;
            fsm_d              = IDLE;
            wb_valid_d         = !flush_i;
            wb_prd_d           = ent_q[cur_q].prd;
            wb_rob_d           = ent_q[cur_q].rob;
            wb_data_d          = ld_extend(bus.mem_resp_data, ent_q[cur_q].addr[1:0],
                                           ent_q[cur_q].size, ent_q[cur_q].is_unsigned);
        end else if (fsm_q == RESP && flush_i) begin
            fsm_d = DRAIN;
        end
        if (fsm_q == DRAIN && bus.mem_resp_valid) fsm_d = IDLE;
        if (flush_i) begin
            for (int i = 0; i < LDB_NUM; i++) ent_d[i].state = FREE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_q      <= '{default: '0};
            fsm_q      <= IDLE;
            cur_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_prd_q   <= '0;
            wb_rob_q   <= '0;
            wb_data_q  <= '0;
        end else begin
            ent_q      <= ent_d;
            fsm_q      <= fsm_d;
            cur_q      <= cur_d;
            wb_valid_q <= wb_valid_d;
            wb_prd_q   <= wb_prd_d;
            wb_rob_q   <= wb_rob_d;
            wb_data_q  <= wb_data_d;
        end
    end
endmodule

// File: tb/tb_load_buffer.sv
// tb_load_buffer: vector table plus flush/full/stall sequences, writebacks checked
// against a queue of expected results pushed when each request is accepted.
module tb_load_buffer;
    import load_buffer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    load_buffer_if bus();
    load_buffer dut (.clk(clk), .rst(rst), .flush_i(flush), .bus(bus));

    typedef struct {
        logic [PRF_WIDTH-1:0] prd;
        logic [ROB_WIDTH-1:0] rob;
        logic [XLEN-1:0]      data;
    } wb_t;

    typedef struct {
        logic [XLEN-1:0]      addr;
        logic [1:0]           size;
        logic                 uns;
        logic [PRF_WIDTH-1:0] prd;
        logic [ROB_WIDTH-1:0] rob;
        logic [XLEN-1:0]      word;
        logic [XLEN-1:0]      exp;
    } vec_t;

    wb_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.wb_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected: got writeback prd %0d data 0x%08h, want none", bus.wb_prd, bus.wb_data);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                check("wb_prd", XLEN'(bus.wb_prd), XLEN'(e.prd));
                check("wb_rob", XLEN'(bus.wb_rob), XLEN'(e.rob));
                check("wb_data", bus.wb_data, e.data);
            end
        end
    end

    task automatic alloc(input logic [XLEN-1:0] a, input logic [1:0] sz, input logic u,
                         input logic [PRF_WIDTH-1:0] prd, input logic [ROB_WIDTH-1:0] rob, input logic exp_ready);
        bus.alloc_valid    = 1'b1;
        bus.alloc_addr     = a;
        bus.alloc_size     = sz;
        bus.alloc_unsigned = u;
        bus.alloc_prd      = prd;
        bus.alloc_rob      = rob;
        #1;
        check("alloc_ready", XLEN'(bus.alloc_ready), XLEN'(exp_ready));
        @(negedge clk);
        bus.alloc_valid = 1'b0;
    endtask

    task automatic accept(input logic [XLEN-1:0] exp_addr, input logic push, input wb_t e);
        int n;
        n = 0;
        while (bus.mem_req_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n == 40) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: got no request in 40 cycles, want addr 0x%08h", exp_addr);
            return;
        end
        check("req_addr", bus.mem_req_addr, exp_addr);
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        if (push) exp_q.push_back(e);
    endtask

    task automatic respond(input int lat, input logic [XLEN-1:0] w);
        repeat (lat - 1) @(negedge clk);
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = w;
        @(negedge clk);
        bus.mem_resp_valid = 1'b0;
        check("wb_pulse", XLEN'(bus.wb_valid), 1);
        @(negedge clk);
        check("wb_single", XLEN'(bus.wb_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before 200000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[8];
        wb_t  e;
        bus.alloc_valid    = 1'b0;
        bus.alloc_addr     = '0;
        bus.alloc_size     = '0;
        bus.alloc_unsigned = 1'b0;
        bus.alloc_prd      = '0;
        bus.alloc_rob      = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        vt[0] = '{32'h100, 2'd2, 1'b0, 6'd5,  5'd3,  32'hDEADBEEF, 32'hDEADBEEF};
        vt[1] = '{32'h103, 2'd0, 1'b0, 6'd10, 5'd4,  32'h80FF0000, 32'hFFFFFF80};
        vt[2] = '{32'h103, 2'd0, 1'b1, 6'd11, 5'd5,  32'h80FF0000, 32'h00000080};
        vt[3] = '{32'h102, 2'd1, 1'b0, 6'd12, 5'd6,  32'h80FF0000, 32'hFFFF80FF};
        vt[4] = '{32'h102, 2'd1, 1'b1, 6'd13, 5'd7,  32'h80FF0000, 32'h000080FF};
        vt[5] = '{32'h201, 2'd0, 1'b0, 6'd14, 5'd8,  32'h00007F00, 32'h0000007F};
        vt[6] = '{32'h300, 2'd1, 1'b0, 6'd15, 5'd9,  32'h12348001, 32'hFFFF8001};
        vt[7] = '{32'h400, 2'd0, 1'b1, 6'd16, 5'd10, 32'hFFFFFFAB, 32'h000000AB};

        repeat (3) @(negedge clk);
        check("rst_wb_valid", XLEN'(bus.wb_valid), 0);
        check("rst_req_valid", XLEN'(bus.mem_req_valid), 0);
        check("rst_wb_prd", XLEN'(bus.wb_prd), 0);
        check("rst_wb_rob", XLEN'(bus.wb_rob), 0);
        check("rst_wb_data", bus.wb_data, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_alloc_ready", XLEN'(bus.alloc_ready), 1);

        // Formatting table: one load at a time, two-cycle cache latency.
        for (int i = 0; i < 8; i++) begin
            alloc(vt[i].addr, vt[i].size, vt[i].uns, vt[i].prd, vt[i].rob, 1'b1);
            e = '{vt[i].prd, vt[i].rob, vt[i].exp};
            accept({vt[i].addr[31:2], 2'b00}, 1'b1, e);
            respond(2, vt[i].word);
        end

        // Fill all 16 slots with the cache stalled; the 17th must be refused.
        for (int i = 0; i < 16; i++) alloc(32'h1000 + 32'(16 * i), 2'd2, 1'b0, 6'(i + 20), 5'(i), 1'b1);
        check("full_ready", XLEN'(bus.alloc_ready), 0);
        alloc(32'h9990, 2'd2, 1'b0, 6'd63, 5'd31, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", XLEN'(bus.mem_req_valid), 1);
            check("hold_addr", bus.mem_req_addr, 32'h1000);
            check("hold_full", XLEN'(bus.alloc_ready), 0);
            @(negedge clk);
        end
        for (int i = 0; i < 16; i++) begin
            e = '{6'(i + 20), 5'(i), 32'h01010101 * 32'(i + 1)};
            accept(32'h1000 + 32'(16 * i), 1'b1, e);
            respond(1, 32'h01010101 * 32'(i + 1));
        end
        check("drained_req", XLEN'(bus.mem_req_valid), 0);
        check("drained_ready", XLEN'(bus.alloc_ready), 1);

        // Flush while waiting for a response with three slots occupied.
        alloc(32'h2000, 2'd2, 1'b0, 6'd40, 5'd1, 1'b1);
        alloc(32'h2004, 2'd2, 1'b0, 6'd41, 5'd2, 1'b1);
        alloc(32'h2008, 2'd2, 1'b0, 6'd42, 5'd3, 1'b1);
        accept(32'h2000, 1'b0, e);
        flush = 1'b1;
        #1;
        check("flush_ready", XLEN'(bus.alloc_ready), 0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_free", XLEN'(bus.alloc_ready), 1);
        check("flush_drop_req", XLEN'(bus.mem_req_valid), 0);
        alloc(32'h3000, 2'd2, 1'b0, 6'd43, 5'd4, 1'b1);
        check("drain_hold", XLEN'(bus.mem_req_valid), 0);
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'hBAD0BAD0;
        @(negedge clk);
        bus.mem_resp_valid = 1'b0;
        check("drain_no_wb", XLEN'(bus.wb_valid), 0);
        e = '{6'd43, 5'd4, 32'hCAFEF00D};
        accept(32'h3000, 1'b1, e);
        respond(2, 32'hCAFEF00D);

        // Response and flush in the same cycle, then allocate right after.
        alloc(32'h4000, 2'd2, 1'b0, 6'd50, 5'd11, 1'b1);
        accept(32'h4000, 1'b0, e);
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'h11112222;
        flush = 1'b1;
        @(negedge clk);
        bus.mem_resp_valid = 1'b0;
        flush = 1'b0;
        check("flush_resp_wb", XLEN'(bus.wb_valid), 0);
        alloc(32'h5001, 2'd0, 1'b1, 6'd51, 5'd12, 1'b1);
        e = '{6'd51, 5'd12, 32'h000000C3};
        accept(32'h5000, 1'b1, e);
        respond(2, 32'h0000C300);

        // Reset in the middle of a transaction clears everything.
        alloc(32'h6000, 2'd2, 1'b0, 6'd60, 5'd13, 1'b1);
        alloc(32'h6004, 2'd2, 1'b0, 6'd61, 5'd14, 1'b1);
        accept(32'h6000, 1'b0, e);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_req", XLEN'(bus.mem_req_valid), 0);
        check("mid_rst_wb", XLEN'(bus.wb_valid), 0);
        check("mid_rst_ready", XLEN'(bus.alloc_ready), 1);
        repeat (3) @(negedge clk);
        check("mid_rst_idle", XLEN'(bus.mem_req_valid), 0);

        check("scoreboard_empty", XLEN'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
